spi_xfer_ctrl: RTL and testbench

- Transfer sequencer behind the SPI-style CSR block (ctrl/intctrl/status/data registers).
- Consumes the register output values (enable, master, mode, prescaler, clk2x, dord, intlvl) and the data-register write strobe.
- Generates SCK/MOSI/CS_n and samples MISO.
- Writes results back through hardware-input next/we pairs: data.rdata, status.if_field, status.wrcol.

---
 rtl/spi_xfer_pkg.sv | 41 ++++
 rtl/spi_xfer_ctrl_sck_gen.sv | 60 ++++++
 rtl/spi_xfer_ctrl.sv | 160 ++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_pkg.sv
// spi_xfer_pkg - shared types, divider table and helpers for the SPI transfer sequencer.
// Rev 1.0
`default_nettype none

package spi_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SPI_DATA_W = 8;
  localparam int HALF_W     = 7;

  localparam logic [7:0] DIV_P0 = 8'd4;
  localparam logic [7:0] DIV_P1 = 8'd16;
  localparam logic [7:0] DIV_P2 = 8'd64;
  localparam logic [7:0] DIV_P3 = 8'd128;

  // System clocks per full SCK period.
  function automatic logic [7:0] div_of(input logic [1:0] prescaler, input logic clk2x);
    logic [7:0] d;
    case (prescaler)
      2'b00:   d = DIV_P0;
      2'b01:   d = DIV_P1;
      2'b10:   d = DIV_P2;
      default: d = DIV_P3;
    endcase
    return clk2x ? (d >> 1) : d;
  endfunction

  function automatic logic [HALF_W-1:0] half_of(input logic [1:0] prescaler, input logic clk2x);
    logic [7:0] d;
    d = div_of(prescaler, clk2x);
    return d[HALF_W:1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_xfer_ctrl_sck_gen.sv
// spi_sck_gen - half-period counter producing leading/trailing edge strobes and SCK.
// Rev 1.0
`default_nettype none

module spi_sck_gen
  import spi_xfer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic              park,
  input  logic              cpol_in,
  input  logic [HALF_W-1:0] half_in,
  output logic              lead,
  output logic              trail,
  output logic              sck
);

  localparam logic [HALF_W-1:0] C_ONE = HALF_W'(1);

  logic [HALF_W-1:0] r_half;
  logic [HALF_W-1:0] r_cnt;
  logic              r_cpol;
  logic              r_sck;
  logic              w_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_half <= '0;
      r_cnt  <= '0;
      r_cpol <= 1'b0;
      r_sck  <= 1'b0;
    end else if (start) begin
      r_half <= half_in;
      r_cnt  <= half_in - C_ONE;
      r_cpol <= cpol_in;
      r_sck  <= cpol_in;
    end else if (run) begin
      if (r_cnt == '0) begin
        r_cnt <= r_half - C_ONE;
        r_sck <= ~r_sck;
      end else begin
        r_cnt <= r_cnt - C_ONE;
      end
    end else if (park) begin
      // Returning to idle: follow the live CPOL rather than the latched one.
      r_cnt <= '0;
      r_sck <= cpol_in;
    end
  end

  assign w_edge = run && (r_cnt == '0);
  assign lead   = w_edge && (r_sck == r_cpol);
  assign trail  = w_edge && (r_sck != r_cpol);
  assign sck    = r_sck;

endmodule

`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl - SPI master transfer sequencer with CSR write-back strobes.
// Rev 1.0
`default_nettype none

module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_enable,
  input  logic              cfg_master,
  input  logic [1:0]        cfg_mode,
  input  logic [1:0]        cfg_prescaler,
  input  logic              cfg_clk2x,
  input  logic              cfg_dord,
  input  logic [1:0]        cfg_intlvl,
  input  logic              if_flag,
  input  logic              tx_wr,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rdata_next,
  output logic              rdata_we,
  output logic              if_next,
  output logic              if_we,
  output logic              wrcol_next,
  output logic              wrcol_we,
  output logic              irq,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int                EDGES     = 2 * DATA_W;
  localparam int                EDGE_W    = $clog2(EDGES + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [EDGE_W-1:0] r_edge;
  logic              r_cpha;
  logic              r_dord;
  logic              r_wrcol;
  logic              r_irq;

  logic              w_active;
  logic              w_start;
  logic              w_run;
  logic              w_park;
  logic              w_lead;
  logic              w_trail;
  logic              w_sample;
  logic              w_shift;
  logic [HALF_W-1:0] w_half;

  assign w_active = cfg_enable && cfg_master;
  assign w_start  = (r_state == IDLE) && tx_wr && w_active;
  assign w_run    = (r_state == SHIFT) && w_active && (r_edge != LAST_EDGE);
  assign w_park   = (w_state_next == IDLE);
  assign w_half   = half_of(cfg_prescaler, cfg_clk2x);

  // CPHA=1 holds the first bit across the first leading edge, so that edge does not shift.
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? (w_lead && (r_edge != '0)) : w_trail;

  spi_sck_gen u_sck_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .run     (w_run),
    .park    (w_park),
    .cpol_in (cfg_mode[1]),
    .half_in (w_half),
    .lead    (w_lead),
    .trail   (w_trail),
    .sck     (sck)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cs_n         = 1'b1;
    busy         = 1'b0;
    mosi         = 1'b0;
    rdata_we     = 1'b0;
    if_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_next = SHIFT;
      end
      SHIFT: begin
        cs_n = 1'b0;
        busy = 1'b1;
        mosi = r_dord ? r_tx[0] : r_tx[DATA_W-1];
        if (!w_active)                w_state_next = IDLE;
        else if (r_edge == LAST_EDGE) w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
        rdata_we     = w_active;
        if_we        = w_active;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_edge <= '0;
      r_cpha <= 1'b0;
      r_dord <= 1'b0;
    end else if (w_start) begin
      r_tx   <= tx_data;
      r_edge <= '0;
      r_cpha <= cfg_mode[0];
      r_dord <= cfg_dord;
    end else if (w_lead || w_trail) begin
      r_edge <= r_edge + EDGE_ONE;
      if (w_sample) begin
        r_rx <= r_dord ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
      end
      if (w_shift) begin
        r_tx <= r_dord ? (r_tx >> 1) : (r_tx << 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrcol <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_wrcol <= tx_wr && (r_state != IDLE);
      r_irq   <= if_flag && (cfg_intlvl != 2'b00);
    end
  end

  assign rdata_next = r_rx;
  assign if_next    = 1'b1;
  assign wrcol_next = 1'b1;
  assign wrcol_we   = r_wrcol;
  assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl - self-checking bench for spi_xfer_ctrl with a behavioural SPI slave.
// Rev 1.0
`default_nettype none

module tb_spi_xfer_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable, cfg_master, cfg_clk2x, cfg_dord;
  logic [1:0]    cfg_mode, cfg_prescaler, cfg_intlvl;
  logic          if_flag, tx_wr;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] rdata_next;
  logic          rdata_we, if_next, if_we, wrcol_next, wrcol_we, irq, busy, sck, mosi, cs_n;
  logic          miso = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_xfer_ctrl #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_master(cfg_master), .cfg_mode(cfg_mode),
    .cfg_prescaler(cfg_prescaler), .cfg_clk2x(cfg_clk2x), .cfg_dord(cfg_dord),
    .cfg_intlvl(cfg_intlvl), .if_flag(if_flag), .tx_wr(tx_wr), .tx_data(tx_data),
    .rdata_next(rdata_next), .rdata_we(rdata_we), .if_next(if_next), .if_we(if_we),
    .wrcol_next(wrcol_next), .wrcol_we(wrcol_we), .irq(irq), .busy(busy),
    .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and bus monitor, evaluated mid-cycle.
  logic          m_cpol = 1'b0, m_cpha = 1'b0, m_dord = 1'b0, loop = 1'b0;
  logic [DW-1:0] s_data = '0, s_rx = '0, we_data = '0;
  logic          prev_sck = 1'b0, prev_cs = 1'b1, busy_at_we = 1'b0, cs_at_we = 1'b0;
  int            s_lead_n = 0, s_rx_n = 0, tog_n = 0, cs_first = -1, cs_last = -1;
  int            we_n = 0, we_cyc = -1, if_n = 0, wrcol_n = 0, wrcol_cyc = -1;

  function automatic logic bit_at(input logic [DW-1:0] d, input logic dord, input int j);
    return dord ? d[j] : d[DW-1-j];
  endfunction

  function automatic int half_of_cfg(input logic [1:0] presc, input logic c2x);
    int div;
    case (presc)
      2'd0:    div = 4;
      2'd1:    div = 16;
      2'd2:    div = 64;
      default: div = 128;
    endcase
    if (c2x) div = div / 2;
    return div / 2;
  endfunction

  always @(negedge clk) begin
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      s_lead_n = 0;
      s_rx_n   = 0;
      s_rx     = '0;
      cs_first = cyc;
      if (!loop && !m_cpha) miso = bit_at(s_data, m_dord, 0);
    end
    if (cs_n === 1'b0) cs_last = cyc;
    if (cs_n === 1'b0 && sck !== prev_sck) begin
      tog_n++;
      if (sck !== m_cpol) begin
        if (!m_cpha) begin
          if (s_rx_n < DW) s_rx[m_dord ? s_rx_n : DW-1-s_rx_n] = mosi;
          s_rx_n++;
        end else begin
          if (!loop && s_lead_n < DW) miso = bit_at(s_data, m_dord, s_lead_n);
          s_lead_n++;
        end
      end else begin
        if (!m_cpha) begin
          s_lead_n++;
          if (!loop && s_lead_n < DW) miso = bit_at(s_data, m_dord, s_lead_n);
        end else begin
          if (s_rx_n < DW) s_rx[m_dord ? s_rx_n : DW-1-s_rx_n] = mosi;
          s_rx_n++;
        end
      end
    end
    if (loop) miso = mosi;
    if (rdata_we === 1'b1) begin
      we_n++; we_cyc = cyc; we_data = rdata_next; busy_at_we = busy; cs_at_we = cs_n;
    end
    if (if_we === 1'b1) if_n++;
    if (wrcol_we === 1'b1) begin wrcol_n++; wrcol_cyc = cyc; end
    prev_sck = sck;
    prev_cs  = cs_n;
  end

  task automatic clear_stats;
    we_n = 0; if_n = 0; wrcol_n = 0; tog_n = 0; cs_first = -1; cs_last = -1; we_cyc = -1;
    wrcol_cyc = -1;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [1:0] presc, input logic c2x,
                         input logic dord);
    cfg_mode = mode; cfg_prescaler = presc; cfg_clk2x = c2x; cfg_dord = dord;
    cfg_enable = 1'b1; cfg_master = 1'b1;
    m_cpol = mode[1]; m_cpha = mode[0]; m_dord = dord;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sck !== 1'b0 || mosi !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: sck=%b mosi=%b cs_n=%b busy=%b irq=%b expected 0 0 1 0 0",
               sck, mosi, cs_n, busy, irq);
    end
    checks++;
    if (rdata_next !== '0 || rdata_we !== 1'b0 || if_we !== 1'b0 || wrcol_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb: rdata=%h we=%b if_we=%b wrcol_we=%b expected 00 0 0 0",
               rdata_next, rdata_we, if_we, wrcol_we);
    end
    checks++;
    if (if_next !== 1'b1 || wrcol_next !== 1'b1) begin
      errors++;
      $display("FAIL next_consts: if_next=%b wrcol_next=%b expected 1 1", if_next, wrcol_next);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_irq;
    logic prev;
    @(posedge clk); #1;
    if_flag = 1'b1; cfg_intlvl = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_lvl0: irq=%b expected 0", irq); end
    @(posedge clk); #1;
    cfg_intlvl = 2'd2;
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: irq=%b expected 0", irq); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: irq=%b expected 1", irq); end
    @(posedge clk); #1;
    if_flag = 1'b0;
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: irq=%b expected 1", irq); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: irq=%b expected 0", irq); end
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if_flag = 1'($urandom); cfg_intlvl = 2'($urandom);
      @(negedge clk);
      checks++;
      if (irq !== prev) begin
        errors++; $display("FAIL irq_rand: irq=%b expected %b", irq, prev);
      end
      prev = if_flag && (cfg_intlvl != 2'd0);
    end
    @(posedge clk); #1;
    if_flag = 1'b0; cfg_intlvl = 2'd0;
  endtask

  task automatic run_frame(input string name, input logic [1:0] mode, input logic [1:0] presc,
                           input logic c2x, input logic dord, input logic [DW-1:0] tx,
                           input logic [DW-1:0] sdata, input bit lp, input int coll_in);
    int h, n, t, coll;
    logic [DW-1:0] exp_rx;
    h = half_of_cfg(presc, c2x);
    n = 2 * DW * h + 2;
    if (coll_in < 0) coll = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n)) : 0;
    else coll = coll_in;
    exp_rx = lp ? tx : sdata;
    @(posedge clk); #1;
    set_cfg(mode, presc, c2x, dord);
    s_data = sdata; loop = lp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sck !== mode[1] || cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: sck=%b cs_n=%b busy=%b expected sck=%b cs_n=1 busy=0",
               name, sck, cs_n, busy, mode[1]);
    end
    @(posedge clk); #1;
    clear_stats();
    t = cyc; tx_wr = 1'b1; tx_data = tx;
    for (int i = 1; i <= n + 3; i++) begin
      @(posedge clk); #1;
      tx_wr   = (i == coll);
      tx_data = (i == coll) ? ~tx : DW'($urandom);
      // Live CSR changes mid-frame must not disturb the latched transfer.
      if (i == 1) begin
        cfg_mode = ~mode; cfg_prescaler = ~presc; cfg_clk2x = ~c2x; cfg_dord = ~dord;
      end
    end
    tx_wr = 1'b0;
    checks++;
    if (we_n != 1 || we_cyc != t + n) begin
      errors++;
      $display("FAIL %s we_timing: pulses=%0d at T+%0d expected 1 at T+%0d",
               name, we_n, we_cyc - t, n);
    end
    checks++;
    if (we_data !== exp_rx) begin
      errors++; $display("FAIL %s rdata: got %h expected %h", name, we_data, exp_rx);
    end
    checks++;
    if (if_n != 1) begin
      errors++; $display("FAIL %s if_we: pulses=%0d expected 1", name, if_n);
    end
    checks++;
    if (busy_at_we !== 1'b0 || cs_at_we !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pins: busy=%b cs_n=%b expected 0 1", name, busy_at_we, cs_at_we);
    end
    checks++;
    if (tog_n != 2 * DW) begin
      errors++; $display("FAIL %s sck_toggles: got %0d expected %0d", name, tog_n, 2 * DW);
    end
    checks++;
    if (cs_first != t + 1 || cs_last != t + n - 1) begin
      errors++;
      $display("FAIL %s cs_window: T+%0d..T+%0d expected T+1..T+%0d",
               name, cs_first - t, cs_last - t, n - 1);
    end
    checks++;
    if (s_rx !== tx) begin
      errors++; $display("FAIL %s mosi_frame: got %h expected %h", name, s_rx, tx);
    end
    checks++;
    if (coll != 0 && (wrcol_n != 1 || wrcol_cyc != t + coll + 1)) begin
      errors++;
      $display("FAIL %s wrcol: pulses=%0d at T+%0d expected 1 at T+%0d",
               name, wrcol_n, wrcol_cyc - t, coll + 1);
    end else if (coll == 0 && wrcol_n != 0) begin
      errors++; $display("FAIL %s wrcol: pulses=%0d expected 0", name, wrcol_n);
    end
  endtask

  // kind 0: drop enable at offset; kind 1: pulse rst at offset.
  task automatic test_interrupt(input string name, input int kind, input int off);
    int t;
    @(posedge clk); #1;
    set_cfg(2'd0, 2'd0, 1'b0, 1'b0);
    s_data = DW'($urandom); loop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_stats();
    t = cyc; tx_wr = 1'b1; tx_data = DW'($urandom);
    for (int i = 1; i <= off; i++) begin
      @(posedge clk); #1;
      tx_wr = 1'b0;
      if (i == off) begin
        if (kind == 0) cfg_enable = 1'b0;
        else rst = 1'b1;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || sck !== 1'b0 || mosi !== 1'b0) begin
      errors++;
      $display("FAIL %s pins_T+%0d: cs_n=%b busy=%b sck=%b mosi=%b expected 1 0 0 0",
               name, cyc - t, cs_n, busy, sck, mosi);
    end
    if (kind == 1) begin
      checks++;
      if (rdata_next !== '0 || irq !== 1'b0 || wrcol_we !== 1'b0) begin
        errors++;
        $display("FAIL %s regs: rdata=%h irq=%b wrcol_we=%b expected 00 0 0",
                 name, rdata_next, irq, wrcol_we);
      end
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (we_n != 0 || if_n != 0) begin
      errors++;
      $display("FAIL %s writeback: rdata_we=%0d if_we=%0d expected 0 0", name, we_n, if_n);
    end
    cfg_enable = 1'b1;
  endtask

  initial begin
    cfg_enable = 1'b0; cfg_master = 1'b0; cfg_mode = 2'd0; cfg_prescaler = 2'd0;
    cfg_clk2x = 1'b0; cfg_dord = 1'b0; cfg_intlvl = 2'd0; if_flag = 1'b0;
    tx_wr = 1'b0; tx_data = '0; rst = 1'b1;

    test_reset();
    test_irq();
    run_frame("mode0_loop", 2'd0, 2'd0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 0);
    run_frame("mode3_lsb", 2'd3, 2'd1, 1'b1, 1'b1, 8'h3C, 8'h81, 1'b0, 0);
    run_frame("collision", 2'd0, 2'd0, 1'b0, 1'b0, 8'h5A, 8'hC3, 1'b0, 10);
    run_frame("coll_done", 2'd0, 2'd0, 1'b0, 1'b0, 8'h96, 8'h1E, 1'b0, 34);
    test_interrupt("abort", 0, 12);
    run_frame("after_abort", 2'd0, 2'd0, 1'b0, 1'b0, 8'hE7, 8'h42, 1'b0, 0);
    test_interrupt("abort_done", 0, 34);
    test_interrupt("reset_mid", 1, 20);
    run_frame("after_reset", 2'd1, 2'd0, 1'b1, 1'b0, 8'h69, 8'hB4, 1'b0, 0);
    // Quiet inactive write must be ignored without a collision.
    @(posedge clk); #1;
    cfg_master = 1'b0; clear_stats(); tx_wr = 1'b1; tx_data = 8'h11;
    @(posedge clk); #1;
    tx_wr = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tog_n != 0 || wrcol_n != 0 || cs_first != -1 || we_n != 0) begin
      errors++;
      $display("FAIL inactive_wr: toggles=%0d wrcol=%0d cs_first=%0d we=%0d expected 0 0 -1 0",
               tog_n, wrcol_n, cs_first, we_n);
    end
    cfg_master = 1'b1;
    for (int k = 0; k < 10; k++) begin
      run_frame("random", 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                DW'($urandom), DW'($urandom), 1'b0, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
